floor_arbiter: RTL and testbench
================================

Name: floor_arbiter

Overview:
Shares one fixed-latency pipelined `floor` unit between two requesters (port 0, port 1) using round-robin arbitration. It issues at most one operand per cycle into the unit. It tags each in-flight operation with its requester ID and steers each result back to the requester that issued it. It also keeps per-requester grant counters for performance bring-up.

Parameters:
LAT, 1, cycles from `fu_x` driven to `fu_y` valid in the `floor` unit; legal range ≥1.
CNT_W, 16, width of each grant counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an operand
req0_x  in  32  requester 0 operand, IEEE-754 single
req0_ready  out  1  requester 0 operand accepted this cycle
res0_valid  out  1  result for requester 0 valid this cycle
res0_y  out  32  result for requester 0
req1_valid  in  1  requester 1 has an operand
req1_x  in  32  requester 1 operand
req1_ready  out  1  requester 1 operand accepted this cycle
res1_valid  out  1  result for requester 1 valid
res1_y  out  32  result for requester 1
fu_x  out  32  operand to `floor` unit, registered
fu_y  in  32  result from `floor` unit
busy  out  1  one or more operations in flight
gnt_cnt0  out  CNT_W  grants issued to requester 0
gnt_cnt1  out  CNT_W  grants issued to requester 1

Behaviour:
- Clocking: single clock `clk`. `rst` is synchronous and active-high. All state updates on the rising edge of `clk`.
- Reset values: `fu_x` = 0, priority pointer `ptr` = 0, all tag stages invalid, `busy` = 0, `res*_valid` = 0, `gnt_cnt0` = `gnt_cnt1` = 0.
- While `rst` = 1, `req0_ready` = `req1_ready` = 0.
- Arbitration is combinational; `req*_ready` is a function of `req*_valid`, `ptr` and `rst` only.
  - Only one requester valid: it is granted.
  - Both valid: the requester selected by `ptr` is granted.
  - Neither valid: no grant.
  - At most one grant per cycle. Ungranted requester keeps its valid/data stable and retries.
- Pointer update on each grant: `ptr` <= ID of the requester not granted. No grant: `ptr` holds.
- Issue: on a grant at edge t, `fu_x` <= granted operand. With no grant, `fu_x` holds its previous value; the unit computes on it, but the result is untagged and discarded.
- Tag pipeline: LAT+1 stages, each holding {valid, id}.
  - Stage 0 loads {grant, granted_id} each cycle.
  - Every stage shifts each cycle, with no stalls.
  - Results have no backpressure; requesters must always accept them.
- Result routing: when the last stage is valid with id = k, `resk_valid` = 1 and `resk_y` = `fu_y` (combinational from the stage and `fu_y`).
  - The other port's valid is 0.
  - `res*_y` is 0 whenever its valid is 0.
- Latency: an operand accepted in cycle t appears on `resk` in cycle t+1+LAT (t+2 for LAT=1).
- Throughput: 1 operation per cycle aggregate. Results return in issue order.
- `busy` = OR of all tag-stage valid bits.
- Grant counters: increment by 1 on each grant to their port and wrap modulo 2^CNT_W, with no saturation.
- Reset mid-operation: all tags are cleared on the reset edge. In-flight results are discarded, and no `res*_valid` pulse appears for them after `rst` deasserts. The first grant is possible in the first cycle with `rst` = 0.
- The block makes no value assumptions about `x`. NaN/Inf/denormal handling belongs to the `floor` unit; results pass through bit-exact.

Test Plan:
1. Reset, then `req0` x = 0x40400000 (3.0) for one cycle, LAT = 1 → `req0_ready` = 1 that cycle, `fu_x` = 0x40400000 next cycle, `res0_valid` = 1 with `res0_y` = 0x40400000 two cycles after accept, `res1_valid` = 0, `gnt_cnt0` = 1.
2. `req1` streams 0xBDCCCCCD, 0x3DCCCCCD, 0xC1480000 on consecutive cycles, `req0` idle → `res1_y` = 0xBF800000, 0x00000000, 0xC1500000 on three consecutive cycles starting at accept+2, with `busy` high throughout.
3. Both valid continuously from reset (`req0` x = 0xC0400000, `req1` x = 0xC2F6CCCD) → grants alternate 0,1,0,1 starting with 0; results alternate `res0` = 0xC0400000 and `res1` = 0xC2F80000 every cycle.
4. Issue 3 ops, assert `rst` one cycle after the third accept → no `res*_valid` pulses after reset, `busy` = 0 after the reset edge, counters = 0, `fu_x` = 0.
5. CNT_W = 4, 17 back-to-back grants to `req0` → `gnt_cnt0` wraps 15 → 0 → 1, `gnt_cnt1` stays 0.
6. LAT = 3: single op x = 0xB99EAC30 on `req0` → `res0_valid` exactly 4 cycles after accept, `res0_y` = 0xBF800000, single-cycle pulse.

Source files
------------

// File: rtl/floor_arbiter.sv
// -----------------------------------------------------------------------------
// floor_arbiter
//
// Purpose:
//   Shares one fixed-latency, fully pipelined `floor` unit between two
//   requesters.
//   - Round-robin arbitration issues at most one operand per cycle.
//   - Each issued operation is tagged with its requester ID.
//   - The tag travels down a shift pipeline that matches the unit latency.
//   - When the tag reaches the end, the unit's result is steered back to the
//     requester that issued it.
//   - Per-requester grant counters support performance bring-up.
//
// Parameters:
//   LAT    cycles from fu_x being driven to fu_y holding the result (>= 1)
//   CNT_W  width of each grant counter (wraps, no saturation)
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   reqN_valid/x       operand offer from requester N (held until accepted)
//   reqN_ready         operand of requester N accepted this cycle
//   resN_valid/y       result for requester N (no backpressure; y is 0 when
//                      valid is 0)
//   fu_x               registered operand into the floor unit
//   fu_y               result from the floor unit, LAT cycles after fu_x
//   busy               at least one tagged operation is in flight
//   gnt_cnt0/1         grants issued to requester 0 / 1
// -----------------------------------------------------------------------------
module floor_arbiter #(
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    input  logic [31:0]      req0_x,
    output logic             req0_ready,
    output logic             res0_valid,
    output logic [31:0]      res0_y,

    input  logic             req1_valid,
    input  logic [31:0]      req1_x,
    output logic             req1_ready,
    output logic             res1_valid,
    output logic [31:0]      res1_y,

    output logic [31:0]      fu_x,
    input  logic [31:0]      fu_y,

    output logic             busy,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    // The tag pipeline is one stage longer than the unit latency. The operand
    // register (fu_x) adds one cycle in front of the unit, and stage 0 is
    // loaded on the same edge as fu_x.
    localparam int NSTG = LAT + 1;

    // -------------------------------------------------------------------------
    // Per-port views of the flat port list, so that the per-port logic below
    // can be written once.
    // -------------------------------------------------------------------------
    logic        req_valid [2];
    logic [31:0] req_x     [2];
    logic        gnt       [2];
    logic        res_valid [2];
    logic [31:0] res_y     [2];

    assign req_valid[0] = req0_valid;
    assign req_valid[1] = req1_valid;
    assign req_x[0]     = req0_x;
    assign req_x[1]     = req1_x;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic            ptr_reg;        // requester favoured when both are valid
    logic [31:0]     fu_x_reg;
    logic [NSTG-1:0] tag_valid_reg;  // bit i = stage i
    logic [NSTG-1:0] tag_id_reg;

    // -------------------------------------------------------------------------
    // Arbitration (combinational)
    // The grant depends only on the valids, the pointer and reset. Operand
    // values are never looked at, so a requester cannot starve itself by
    // changing its data.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt[0] = 1'b0;
        gnt[1] = 1'b0;
        if (!rst) begin
            if (req_valid[0] && req_valid[1]) begin
                gnt[0] = ~ptr_reg;
                gnt[1] = ptr_reg;
            end else begin
                gnt[0] = req_valid[0];
                gnt[1] = req_valid[1];
            end
        end
    end

    logic        gnt_any;
    logic        gnt_id;
    logic [31:0] gnt_x;

    assign gnt_any = gnt[0] | gnt[1];
    assign gnt_id  = gnt[1];
    assign gnt_x   = gnt[1] ? req_x[1] : req_x[0];

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // -------------------------------------------------------------------------
    // Pointer and operand register
    // With no grant, fu_x keeps its old value. The unit keeps computing on it,
    // but no tag accompanies that result, so it is never delivered.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg  <= 1'b0;
            fu_x_reg <= 32'd0;
        end else if (gnt_any) begin
            ptr_reg  <= ~gnt_id;  // the loser of this round is favoured next
            fu_x_reg <= gnt_x;
        end
    end

    assign fu_x = fu_x_reg;

    // -------------------------------------------------------------------------
    // Tag pipeline: free-running shift with no stalls.
    // - Stage 0 captures this cycle's grant.
    // - The last stage lines up with fu_y.
    // - Reset clears every stage, so in-flight results are dropped.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
        end else begin
            tag_valid_reg <= {tag_valid_reg[NSTG-2:0], gnt_any};
            tag_id_reg    <= {tag_id_reg[NSTG-2:0], gnt_id};
        end
    end

    assign busy = |tag_valid_reg;

    logic last_valid;
    logic last_id;

    assign last_valid = tag_valid_reg[NSTG-1];
    assign last_id    = tag_id_reg[NSTG-1];

    // -------------------------------------------------------------------------
    // Per-port result steering and grant counters
    // Result valid is suppressed while rst is high. Any tag still in the last
    // stage belongs to an operation that the reset is discarding.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [CNT_W-1:0] cnt_reg;

        assign res_valid[gi] = !rst && last_valid && (last_id == 1'(gi));
        assign res_y[gi]     = res_valid[gi] ? fu_y : 32'd0;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (gnt[gi]) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign res0_valid = res_valid[0];
    assign res0_y     = res_y[0];
    assign res1_valid = res_valid[1];
    assign res1_y     = res_y[1];

    assign gnt_cnt0 = g_port[0].cnt_reg;
    assign gnt_cnt1 = g_port[1].cnt_reg;

endmodule

// File: tb/tb_floor_arbiter.sv
// -----------------------------------------------------------------------------
// tb_floor_arbiter
//
// Three arbiter instances are driven from the same requester stimulus:
//   cfg0  LAT=1, CNT_W=16
//   cfg1  LAT=1, CNT_W=4   (counter wrap)
//   cfg2  LAT=3, CNT_W=16  (longer latency)
//
// Each instance is wrapped around its own behavioural floor unit.
//
// Stimulus side:
//   - Computes the expected grant from a round-robin reference.
//   - Checks the ready outputs, fu_x and the counters.
//   - Pushes each accepted operation into a shared scoreboard, tagged with
//     its hand-computed floor result.
//
// Monitor side:
//   - One monitor per instance, each with its own read pointer into the
//     scoreboard.
//   - Pops an entry whenever a result is presented.
//   - Checks ID, data and arrival cycle, and also checks busy.
// -----------------------------------------------------------------------------
module tb_floor_arbiter;

    localparam int NCFG = 3;

    typedef struct {
        bit          id;
        logic [31:0] y;
        int          acc;
    } op_t;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req1_valid = 1'b0;
    logic [31:0] req0_x     = 32'd0;
    logic [31:0] req1_x     = 32'd0;

    logic        rdy0_w [NCFG];
    logic        rdy1_w [NCFG];
    logic [31:0] fux_w  [NCFG];
    logic [15:0] cnt0_w [NCFG];
    logic [15:0] cnt1_w [NCFG];

    int  cyc    = 0;
    bit  mon_en = 1'b0;
    bit  rst_hist [0:4095];
    op_t sb [$];
    int  rd_idx [NCFG];
    int  n_chk  = 0;
    int  n_pass = 0;

    // Reference state for the arbiter
    bit          ptr_m  = 1'b0;
    int          cnt0_m = 0;
    int          cnt1_m = 0;
    logic [31:0] fux_m  = 32'd0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cyc < 4096) rst_hist[cyc] <= rst;
        cyc <= cyc + 1;
    end

    task automatic chk(input bit ok, input string nm, input string act, input string req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s @cycle %0d: got %s, expected %s", nm, cyc, act, req);
    endtask

    // Bit-level IEEE-754 single floor, used by the behavioural floor unit.
    function automatic logic [31:0] fp_floor(input logic [31:0] x);
        logic [7:0]  e;
        logic [31:0] mask;
        int          fb;
        e = x[30:23];
        if (e >= 8'd150) return x;              // integer, Inf or NaN
        if (e < 8'd127) begin                   // |x| < 1
            if (x[30:0] == 31'd0) return x;
            return x[31] ? 32'hBF80_0000 : 32'h0000_0000;
        end
        fb   = 150 - int'(e);
        mask = (32'd1 << fb) - 32'd1;
        if ((x & mask) == 32'd0) return x;
        if (!x[31]) return x & ~mask;
        return {1'b1, 31'((x[30:0] & ~mask[30:0]) + (31'd1 << fb))};
    endfunction

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int L = (gi == 2) ? 3 : 1;
        localparam int W = (gi == 1) ? 4 : 16;

        logic         r0, r1, v0, v1, bsy;
        logic [31:0]  y0, y1, fux, fuy;
        logic [W-1:0] c0, c1;
        logic [31:0]  fpipe [L];

        floor_arbiter #(.LAT(L), .CNT_W(W)) dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (req0_valid),
            .req0_x     (req0_x),
            .req0_ready (r0),
            .res0_valid (v0),
            .res0_y     (y0),
            .req1_valid (req1_valid),
            .req1_x     (req1_x),
            .req1_ready (r1),
            .res1_valid (v1),
            .res1_y     (y1),
            .fu_x       (fux),
            .fu_y       (fuy),
            .busy       (bsy),
            .gnt_cnt0   (c0),
            .gnt_cnt1   (c1)
        );

        // Behavioural floor unit: LAT register stages after fu_x.
        always @(posedge clk) begin
            fpipe[0] <= fp_floor(fux);
            for (int i = 1; i < L; i++) fpipe[i] <= fpipe[i-1];
        end
        assign fuy = fpipe[L-1];

        assign rdy0_w[gi] = r0;
        assign rdy1_w[gi] = r1;
        assign fux_w[gi]  = fux;
        assign cnt0_w[gi] = 16'(c0);
        assign cnt1_w[gi] = 16'(c1);

        initial rd_idx[gi] = 0;

        always @(negedge clk) begin : mon
            op_t op;
            int  exp_c;
            bit  killed;
            bit  busy_e;
            if (mon_en) begin
                // Retire operations whose result a reset has discarded.
                while (rd_idx[gi] < sb.size()) begin
                    op     = sb[rd_idx[gi]];
                    exp_c  = op.acc + 1 + L;
                    killed = 1'b0;
                    for (int c = op.acc + 1; c <= exp_c && c <= cyc; c++)
                        if ((c == cyc) ? rst : rst_hist[c]) killed = 1'b1;
                    if (!killed) break;
                    rd_idx[gi]++;
                end

                if (v0 || v1) begin
                    if (rd_idx[gi] >= sb.size()) begin
                        chk(1'b0, $sformatf("cfg%0d unexpected_result", gi),
                            $sformatf("v0=%0b v1=%0b", v0, v1), "no result");
                    end else begin
                        op    = sb[rd_idx[gi]];
                        exp_c = op.acc + 1 + L;
                        chk((v0 != v1) && (v1 == op.id) && ((v1 ? y1 : y0) == op.y)
                                && ((v1 ? y0 : y1) == 32'd0) && (cyc == exp_c),
                            $sformatf("cfg%0d result", gi),
                            $sformatf("v0=%0b v1=%0b y0=%h y1=%h cycle=%0d", v0, v1, y0, y1, cyc),
                            $sformatf("port%0d y=%h cycle=%0d", op.id, op.y, exp_c));
                        rd_idx[gi]++;
                    end
                end else if (rd_idx[gi] < sb.size()
                             && sb[rd_idx[gi]].acc + 1 + L <= cyc) begin
                    op = sb[rd_idx[gi]];
                    chk(1'b0, $sformatf("cfg%0d missing_result", gi), "no valid",
                        $sformatf("port%0d y=%h", op.id, op.y));
                    rd_idx[gi]++;
                end else begin
                    chk(y0 == 32'd0 && y1 == 32'd0, $sformatf("cfg%0d idle_res_y", gi),
                        $sformatf("y0=%h y1=%h", y0, y1), "both zero");
                end

                // busy: any accepted op whose tag window covers this cycle and
                // was not cleared by a reset edge before this cycle.
                busy_e = 1'b0;
                for (int k = sb.size() - 1; k >= 0 && sb[k].acc >= cyc - 1 - L; k--) begin
                    if (sb[k].acc + 1 <= cyc && cyc <= sb[k].acc + 1 + L) begin
                        killed = 1'b0;
                        for (int c = sb[k].acc + 1; c < cyc; c++)
                            if (rst_hist[c]) killed = 1'b1;
                        if (!killed) busy_e = 1'b1;
                    end
                end
                chk(bsy == busy_e, $sformatf("cfg%0d busy", gi),
                    $sformatf("%0b", bsy), $sformatf("%0b", busy_e));
            end
        end
    end

    // One cycle of stimulus. ya/yb are the hand-computed floor results that
    // are expected back if the operand is accepted.
    task automatic step(input bit a0, input logic [31:0] xa, input logic [31:0] ya,
                        input bit a1, input logic [31:0] xb, input logic [31:0] yb,
                        input bit r);
        bit g0;
        bit g1;
        bit ok;
        rst        = r;
        req0_valid = a0;
        req0_x     = xa;
        req1_valid = a1;
        req1_x     = xb;
        @(negedge clk);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!r) begin
            if (a0 && a1) begin
                g0 = ~ptr_m;
                g1 = ptr_m;
            end else begin
                g0 = a0;
                g1 = a1;
            end
        end
        ok = 1'b1;
        for (int i = 0; i < NCFG; i++)
            if (rdy0_w[i] != g0 || rdy1_w[i] != g1) ok = 1'b0;
        chk(ok, "ready", $sformatf("r0=%0b r1=%0b", rdy0_w[0], rdy1_w[0]),
            $sformatf("r0=%0b r1=%0b", g0, g1));
        if (g0) sb.push_back('{id: 1'b0, y: ya, acc: cyc});
        if (g1) sb.push_back('{id: 1'b1, y: yb, acc: cyc});
        if (g0 || g1)
            $display("cycle %0d: grant port%0d x=%h expect y=%h", cyc, g1,
                     g1 ? xb : xa, g1 ? yb : ya);

        @(posedge clk);
        if (r) begin
            ptr_m  = 1'b0;
            cnt0_m = 0;
            cnt1_m = 0;
            fux_m  = 32'd0;
        end else if (g0) begin
            ptr_m = 1'b1;
            cnt0_m++;
            fux_m = xa;
        end else if (g1) begin
            ptr_m = 1'b0;
            cnt1_m++;
            fux_m = xb;
        end
        #1;
        ok = 1'b1;
        for (int i = 0; i < NCFG; i++)
            if (fux_w[i] != fux_m) ok = 1'b0;
        chk(ok, "fu_x", $sformatf("%h", fux_w[0]), $sformatf("%h", fux_m));
        chk(cnt0_w[0] == 16'(cnt0_m) && cnt0_w[1] == 16'(cnt0_m % 16)
                && cnt0_w[2] == 16'(cnt0_m)
                && cnt1_w[0] == 16'(cnt1_m) && cnt1_w[1] == 16'(cnt1_m % 16)
                && cnt1_w[2] == 16'(cnt1_m),
            "gnt_cnt",
            $sformatf("c0=%0d/%0d/%0d c1=%0d/%0d/%0d", cnt0_w[0], cnt0_w[1], cnt0_w[2],
                      cnt1_w[0], cnt1_w[1], cnt1_w[2]),
            $sformatf("c0=%0d/%0d c1=%0d/%0d", cnt0_m, cnt0_m % 16, cnt1_m, cnt1_m % 16));
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, r);
    endtask

    initial begin
        // Reset
        idle(3, 1'b1);
        mon_en = 1'b1;

        // Single op on port 0: 3.0 -> 3.0
        step(1'b1, 32'h4040_0000, 32'h4040_0000, 1'b0, 32'd0, 32'd0, 1'b0);
        idle(5, 1'b0);

        // Port 1 stream: -0.1, 0.1, -12.5, NaN, -0.0
        step(1'b0, 32'd0, 32'd0, 1'b1, 32'hBDCC_CCCD, 32'hBF80_0000, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 32'h3DCC_CCCD, 32'h0000_0000, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 32'hC148_0000, 32'hC150_0000, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        idle(5, 1'b0);

        // Both valid continuously from reset: grants alternate 0,1,0,1,...
        idle(2, 1'b1);
        for (int i = 0; i < 6; i++)
            step(1'b1, 32'hC040_0000, 32'hC040_0000,
                 1'b1, 32'hC2F6_CCCD, 32'hC2F8_0000, 1'b0);
        idle(5, 1'b0);

        // Three ops, then reset one cycle after the third accept
        step(1'b1, 32'h4020_0000, 32'h4000_0000, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 32'hC020_0000, 32'hC040_0000, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 32'h3FC0_0000, 32'h3F80_0000, 1'b0, 32'd0, 32'd0, 1'b0);
        idle(1, 1'b1);
        idle(6, 1'b0);

        // 17 back-to-back grants to port 0 (wraps the 4-bit counter)
        for (int i = 0; i < 17; i++) begin
            if (i % 2 == 0)
                step(1'b1, 32'h3FC0_0000, 32'h3F80_0000, 1'b0, 32'd0, 32'd0, 1'b0);
            else
                step(1'b1, 32'h4020_0000, 32'h4000_0000, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        idle(5, 1'b0);

        // Tiny negative value floors to -1.0 (latency visible in cfg2)
        step(1'b1, 32'hB99E_AC30, 32'hBF80_0000, 1'b0, 32'd0, 32'd0, 1'b0);
        idle(8, 1'b0);

        for (int i = 0; i < NCFG; i++)
            chk(rd_idx[i] == sb.size(), $sformatf("cfg%0d drained", i),
                $sformatf("%0d consumed", rd_idx[i]), $sformatf("%0d", sb.size()));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
